uart_core: RTL and testbench

Full-duplex 8N1-style UART with an independent receiver and transmitter sharing one clock and one asynchronous reset. It sits between the board RX/TX pins and the design's byte-level state machines: it accepts a one-cycle start pulse plus a data byte and serialises it, and it delivers received bytes with a one-cycle valid strobe. Bit timing is derived from clock-frequency and bit-rate parameters; no external baud tick is needed.

---
 rtl/uart_core_if.sv | 24 ++
 rtl/uart_core.sv | 165 ++++++++++++++++
 tb/tb_uart_core.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_core_if.sv
// rtl/uart_core_if.sv - serial pins and byte handshake bundle for uart_core
interface uart_core_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic                    uart_rxd;
  logic                    uart_rx_en;
  logic                    uart_rx_break;
  logic                    uart_rx_valid;
  logic [PAYLOAD_BITS-1:0] uart_rx_data;
  logic                    uart_txd;
  logic                    uart_tx_en;
  logic                    uart_tx_busy;
  logic [PAYLOAD_BITS-1:0] uart_tx_data;

  modport slave (
    input  uart_rxd, uart_rx_en, uart_tx_en, uart_tx_data,
    output uart_rx_break, uart_rx_valid, uart_rx_data, uart_txd, uart_tx_busy
  );

  modport master (
    output uart_rxd, uart_rx_en, uart_tx_en, uart_tx_data,
    input  uart_rx_break, uart_rx_valid, uart_rx_data, uart_txd, uart_tx_busy
  );
endinterface

// File: rtl/uart_core.sv
// rtl/uart_core.sv - full-duplex 8N1 UART, bit timing from CLK_HZ/BIT_RATE
// Optional break detection enabled by defining UART_RX_BREAK_EN.
module uart_core #(
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int CLK_HZ       = 12_000_000
) (
  input  logic        clk,
  input  logic        resetn,
  uart_core_if.slave  u
);
  localparam int CPB   = CLK_HZ / BIT_RATE;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);
  localparam int BIT_W = $clog2(PAYLOAD_BITS);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------- transmitter ----------------
  state_t                  tx_state, tx_next;
  logic [CNT_W-1:0]        tx_cnt;
  logic [BIT_W-1:0]        tx_bit;
  logic [PAYLOAD_BITS-1:0] tx_shreg;
  logic                    tx_bit_end;

  assign tx_bit_end = (tx_cnt == CNT_W'(CPB-1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tx_state <= S_IDLE;
    else         tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      S_IDLE:  if (u.uart_tx_en) tx_next = S_START;
      S_START: if (tx_bit_end) tx_next = S_DATA;
      S_DATA:  if (tx_bit_end && tx_bit == BIT_W'(PAYLOAD_BITS-1)) tx_next = S_STOP;
      S_STOP:  if (tx_bit_end) tx_next = S_IDLE;
      default: tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
    end else begin
      if (tx_state == S_IDLE || tx_bit_end) tx_cnt <= '0;
      else                                  tx_cnt <= tx_cnt + CNT_W'(1);
      if (tx_state == S_IDLE) begin
        tx_bit <= '0;
        if (u.uart_tx_en) tx_shreg <= u.uart_tx_data;
      end else if (tx_state == S_DATA && tx_bit_end) begin
        tx_bit   <= tx_bit + BIT_W'(1);
        tx_shreg <= tx_shreg >> 1;
      end
    end
  end

  // Line decoded straight from state so reset returns it high without a clock edge.
  assign u.uart_txd     = (tx_state == S_START) ? 1'b0 :
                          (tx_state == S_DATA)  ? tx_shreg[0] : 1'b1;
  assign u.uart_tx_busy = (tx_state != S_IDLE);

  // ---------------- receiver ----------------
  logic                    rxd_s1, rxd_s2, rxd_s3;
  logic                    rx_fall, rx_sample, rx_armed;
  state_t                  rx_state, rx_next;
  logic [CNT_W-1:0]        rx_cnt;
  logic [BIT_W-1:0]        rx_bit;
  logic [PAYLOAD_BITS-1:0] rx_shreg, rx_data_q;
  logic                    rx_valid_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) {rxd_s1, rxd_s2, rxd_s3} <= 3'b111;
    else         {rxd_s1, rxd_s2, rxd_s3} <= {u.uart_rxd, rxd_s1, rxd_s2};
  end

  assign rx_fall   = rxd_s3 & ~rxd_s2;
  // Start bit is checked at its midpoint; every later sample is one bit time on.
  assign rx_sample = (rx_state == S_START) ? (rx_cnt == CNT_W'(HALF-1))
                                           : (rx_cnt == CNT_W'(CPB-1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rx_state <= S_IDLE;
    else         rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    if (!u.uart_rx_en) begin
      rx_next = S_IDLE;
    end else begin
      case (rx_state)
        S_IDLE:  if (rx_fall && rx_armed) rx_next = S_START;
        S_START: if (rx_sample) rx_next = rxd_s2 ? S_IDLE : S_DATA;
        S_DATA:  if (rx_sample && rx_bit == BIT_W'(PAYLOAD_BITS-1)) rx_next = S_STOP;
        S_STOP:  if (rx_sample) rx_next = S_IDLE;
        default: rx_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shreg   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (rx_state == S_IDLE || rx_sample) rx_cnt <= '0;
      else                                 rx_cnt <= rx_cnt + CNT_W'(1);
      if (rx_state != S_DATA) begin
        rx_bit <= '0;
      end else if (rx_sample) begin
        rx_bit   <= rx_bit + BIT_W'(1);
        rx_shreg <= {rxd_s2, rx_shreg[PAYLOAD_BITS-1:1]};
      end
      if (rx_state == S_STOP && rx_sample && u.uart_rx_en && rxd_s2) begin
        rx_data_q  <= rx_shreg;
        rx_valid_q <= 1'b1;
      end
    end
  end

  assign u.uart_rx_valid = rx_valid_q;
  assign u.uart_rx_data  = rx_data_q;

`ifdef UART_RX_BREAK_EN
  logic             rx_zero, rx_break_q;
  logic [CNT_W-1:0] rx_hi_cnt;

  // After a break the line must sit high for a full bit before a new start is trusted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_zero    <= 1'b0;
      rx_armed   <= 1'b1;
      rx_hi_cnt  <= '0;
      rx_break_q <= 1'b0;
    end else begin
      rx_break_q <= 1'b0;
      if (rx_state == S_START)                          rx_zero <= 1'b1;
      else if (rx_state == S_DATA && rx_sample && rxd_s2) rx_zero <= 1'b0;
      if (rx_state == S_STOP && rx_sample && u.uart_rx_en && !rxd_s2 && rx_zero) begin
        rx_break_q <= 1'b1;
        rx_armed   <= 1'b0;
        rx_hi_cnt  <= '0;
      end else if (!rx_armed) begin
        if (!rxd_s2)                              rx_hi_cnt <= '0;
        else if (rx_hi_cnt == CNT_W'(CPB-1))      rx_armed  <= 1'b1;
        else                                      rx_hi_cnt <= rx_hi_cnt + CNT_W'(1);
      end
    end
  end

  assign u.uart_rx_break = rx_break_q;
`else
  assign rx_armed        = 1'b1;
  assign u.uart_rx_break = 1'b0;
`endif
endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - randomized self-checking bench for uart_core, CYCLES_PER_BIT=10
module tb_uart_core;
  localparam int CPB = 10;
`ifdef UART_RX_BREAK_EN
  localparam int EXP_BREAKS = 1;
`else
  localparam int EXP_BREAKS = 0;
`endif

  logic clk = 1'b0;
  logic resetn;
  logic rxd_drv;
  logic loop;

  uart_core_if #(.PAYLOAD_BITS(8)) u();

  uart_core #(.BIT_RATE(100_000), .PAYLOAD_BITS(8), .CLK_HZ(1_000_000)) dut (
    .clk    (clk),
    .resetn (resetn),
    .u      (u)
  );

  always #5 clk = ~clk;
  assign u.uart_rxd = loop ? u.uart_txd : rxd_drv;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] rx_got[$];
  logic [7:0] rx_exp[$];
  logic [7:0] model_data = 8'h00;
  int break_cnt = 0;
  int dbl_valid = 0;
  logic prev_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (u.uart_rx_valid === 1'b1) begin
        rx_got.push_back(u.uart_rx_data);
        if (prev_valid) dbl_valid++;
      end
      if (u.uart_rx_break === 1'b1) break_cnt++;
      prev_valid = (u.uart_rx_valid === 1'b1);
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Reference: a good frame (stop=1) yields exactly its byte; anything else yields nothing.
  task automatic drive_rx(input logic [7:0] d, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, d, 1'b0};
    if (stop_bit) begin
      rx_exp.push_back(d);
      model_data = d;
    end
    for (int b = 0; b < 10; b++) begin
      rxd_drv = f[b];
      repeat (CPB) @(negedge clk);
    end
    rxd_drv = 1'b1;
  endtask

  task automatic check_rx(input string tag);
    check_eq({tag, "_count"}, rx_got.size(), rx_exp.size());
    while (rx_got.size() > 0 && rx_exp.size() > 0)
      check_eq({tag, "_data"}, rx_got.pop_front(), rx_exp.pop_front());
    rx_got.delete();
    rx_exp.delete();
  endtask

  task automatic tx_frame_check(input string tag, input logic [7:0] d);
    logic [9:0] f;
    int bad, n;
    f = {1'b1, d, 1'b0};
    @(negedge clk);
    u.uart_tx_en   = 1'b1;
    u.uart_tx_data = d;
    @(negedge clk);
    u.uart_tx_en   = 1'b0;
    u.uart_tx_data = 8'($urandom);
    bad = 0;
    n   = 0;
    while (u.uart_tx_busy === 1'b1 && n < 200) begin
      if (n < 10 * CPB && u.uart_txd !== f[n / CPB]) bad++;
      n++;
      @(negedge clk);
    end
    check_eq({tag, "_busy_cycles"}, n, 10 * CPB);
    check_eq({tag, "_txd_bad_cycles"}, bad, 0);
    check_eq({tag, "_txd_idle"}, u.uart_txd, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, n;
    logic [7:0] seq [3];
    resetn = 1'b0;
    rxd_drv = 1'b1;
    loop = 1'b0;
    u.uart_rx_en = 1'b1;
    u.uart_tx_en = 1'b0;
    u.uart_tx_data = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (u.uart_txd !== 1'b1 || u.uart_tx_busy !== 1'b0 || u.uart_rx_valid !== 1'b0 ||
          u.uart_rx_data !== 8'h00 || u.uart_rx_break !== 1'b0) bad++;
    end
    check_eq("reset_idle_bad_cycles", bad, 0);
    check_eq("reset_rx_data", u.uart_rx_data, 8'h00);

    tx_frame_check("tx_a5", 8'hA5);

    drive_rx(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    check_eq("rx_3c_value", u.uart_rx_data, 8'h3C);
    check_rx("rx_3c");
    check_eq("rx_3c_break", break_cnt, 0);

    // Loopback, tx_en held high: three frames separated by a single idle cycle.
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h55;
    for (int k = 0; k < 3; k++) rx_exp.push_back(seq[k]);
    model_data = 8'h55;
    loop = 1'b1;
    @(negedge clk);
    u.uart_tx_en   = 1'b1;
    u.uart_tx_data = seq[0];
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (u.uart_tx_busy !== 1'b1 && n < 50);
      check_eq("b2b_gap", n, 1);
      if (k < 2) u.uart_tx_data = seq[k+1];
      else       u.uart_tx_en   = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (u.uart_tx_busy === 1'b1 && n < 200);
      check_eq("b2b_busy_cycles", n, 10 * CPB);
    end
    repeat (30) @(negedge clk);
    loop = 1'b0;
    check_rx("b2b");

    // Independent random TX and RX traffic at the same time.
    for (int i = 0; i < 4; i++) begin
      fork
        tx_frame_check("rand_tx", 8'($urandom));
        drive_rx(8'($urandom), 1'b1);
      join
      repeat (20) @(negedge clk);
    end
    check_rx("rand_rx");
    check_eq("rand_rx_value", u.uart_rx_data, model_data);

    // Receiver disabled mid-frame: frame is abandoned.
    fork
      drive_rx(8'($urandom), 1'b1);
      begin repeat (40) @(negedge clk); u.uart_rx_en = 1'b0; end
    join
    rx_exp.delete();
    rx_exp.push_back(model_data);
    rx_exp.delete();
    repeat (20) @(negedge clk);
    u.uart_rx_en = 1'b1;
    check_eq("rx_en_abort_count", rx_got.size(), 0);
    rx_got.delete();
    drive_rx(8'($urandom), 1'b1);
    repeat (20) @(negedge clk);
    check_rx("rx_after_enable");

    // Framing error keeps old data, then a long low line.
    drive_rx(8'h41, 1'b0);
    repeat (20) @(negedge clk);
    check_eq("frame_err_hold", u.uart_rx_data, model_data);
    rxd_drv = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("break_pulses", break_cnt, EXP_BREAKS);
    check_rx("frame_err_break");
    drive_rx(8'($urandom), 1'b1);
    repeat (20) @(negedge clk);
    check_rx("rx_after_break");

    // Asynchronous reset in the middle of both a TX and an RX frame.
    @(negedge clk);
    u.uart_tx_en   = 1'b1;
    u.uart_tx_data = 8'($urandom);
    rxd_drv        = 1'b0;
    @(negedge clk);
    u.uart_tx_en = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      rxd_drv = 1'($urandom);
      repeat (CPB) @(negedge clk);
    end
    check_eq("rst_pre_busy", u.uart_tx_busy, 1);
    #2 resetn = 1'b0;
    #1;
    check_eq("rst_txd", u.uart_txd, 1);
    check_eq("rst_busy", u.uart_tx_busy, 0);
    check_eq("rst_valid", u.uart_rx_valid, 0);
    check_eq("rst_rx_data", u.uart_rx_data, 8'h00);
    rxd_drv = 1'b1;
    model_data = 8'h00;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (150) @(negedge clk);
    check_rx("rst_no_valid");
    check_eq("rst_data_kept", u.uart_rx_data, 8'h00);
    drive_rx(8'($urandom), 1'b1);
    repeat (20) @(negedge clk);
    check_rx("rx_after_reset");
    check_eq("rx_after_reset_value", u.uart_rx_data, model_data);

    check_eq("valid_back_to_back", dbl_valid, 0);
    check_eq("break_total", break_cnt, EXP_BREAKS);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
